// File: rtl/cohort_lifecycle_pkg.sv
// rtl/cohort_lifecycle_pkg.sv - shared types and constants for the consumer lifecycle sequencer
//
// Purpose: state/command encodings, drain qualification length and the
// per-state output decode shared by the lifecycle controller.
// Ports: none (package).

package cohort_lifecycle_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_DRAIN = 3'd4,
      ST_ERROR = 3'd5
   } lifecycle_state_e;

   typedef enum logic [1:0] {
      CMD_NOP   = 2'd0,
      CMD_START = 2'd1,
      CMD_STOP  = 2'd2,
      CMD_CLEAR = 2'd3
   } lifecycle_cmd_e;

   // ctrl_idle must be seen this many consecutive cycles before DRAIN ends
   localparam int DRAIN_IDLE_CYCLES = 2;

   typedef struct packed {
      logic cmd_ready;
      logic monitor_on;
      logic manual_reset;
   } lifecycle_outs_t;

   // Output levels a state presents; loaded into the output register on entry
   function automatic lifecycle_outs_t outs_of(input lifecycle_state_e s);
      lifecycle_outs_t o;
      o.cmd_ready    = (s == ST_IDLE) || (s == ST_RUN) || (s == ST_ERROR);
      o.monitor_on   = (s == ST_ARM) || (s == ST_HOLD) || (s == ST_RUN);
      o.manual_reset = (s == ST_RUN) || (s == ST_DRAIN);
      return o;
   endfunction

endpackage

// File: rtl/lifecycle_timer.sv
// rtl/lifecycle_timer.sv - state-residency timeout counter shared by ARM and DRAIN
//
// Purpose: counts cycles while enabled, held at zero while cleared, and
// flags expiry on the cycle that is the limit-th cycle of residency.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force count to zero (asserted outside the timed states)
//   enable     : count this cycle
//   limit      : timeout in cycles, 0 disables
//   expire     : combinational, high on the last permitted cycle

module lifecycle_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expire
);

   logic [W-1:0] count;
   logic [W-1:0] limit_m1;

   assign limit_m1 = limit - W'(1);

   // >= rather than == so a limit lowered below the running count fires at once
   assign expire = enable && (limit != '0) && (count >= limit_m1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/consumer_lifecycle_ctrl.sv
// rtl/consumer_lifecycle_ctrl.sv - start/stop/clear sequencer for one cohort consumer slice
//
// Purpose: turns single-cycle commands into ordered monitor_on / manual_reset
// controls with element-fetch hold, drain qualification and timeouts.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   cmd_valid/cmd_op  : command strobe and opcode (NOP/START/STOP/CLEAR)
//   cmd_ready         : command accepted when cmd_valid & cmd_ready
//   element_fetched   : coherency manager has its config element
//   ctrl_idle         : fifo_controller has nothing outstanding
//   timeout_limit     : ARM/DRAIN timeout, 0 disables
//   manual_reset      : 1 releases the slice
//   monitor_on        : coherency monitor enable
//   state_o           : current state encoding
//   err_timeout       : sticky timeout flag
//   run_cycles        : saturating count of cycles spent in RUN

module consumer_lifecycle_ctrl
   import cohort_lifecycle_pkg::*;
#(
   parameter int RESET_CYCLES = 16,
   parameter int TIMEOUT_W    = 16,
   parameter int RUNCNT_W     = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   input  logic [1:0]           cmd_op,
   output logic                 cmd_ready,
   input  logic                 element_fetched,
   input  logic                 ctrl_idle,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   output logic                 manual_reset,
   output logic                 monitor_on,
   output logic [2:0]           state_o,
   output logic                 err_timeout,
   output logic [RUNCNT_W-1:0]  run_cycles
);

   localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
   localparam int IDLE_W = $clog2(DRAIN_IDLE_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [IDLE_W-1:0] DRAIN_LAST = IDLE_W'(DRAIN_IDLE_CYCLES - 1);

   lifecycle_state_e   state;
   lifecycle_outs_t    outs;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [IDLE_W-1:0]  idle_cnt;
   logic               cmd_acc;
   logic               tmr_enable;
   logic               tmr_expire;
   logic               drain_exit;

   assign cmd_ready    = outs.cmd_ready;
   assign monitor_on   = outs.monitor_on;
   assign manual_reset = outs.manual_reset;
   assign state_o      = state;

   assign cmd_acc    = cmd_valid && outs.cmd_ready;
   assign tmr_enable = (state == ST_ARM) || (state == ST_DRAIN);
   assign drain_exit = ctrl_idle && (idle_cnt == DRAIN_LAST);

   // ARM and DRAIN are never adjacent, so holding the timer clear outside
   // them is the same as clearing it on every state entry
   lifecycle_timer #(.W(TIMEOUT_W)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!tmr_enable),
      .enable (tmr_enable),
      .limit  (timeout_limit),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         outs        <= outs_of(ST_IDLE);
         err_timeout <= 1'b0;
         run_cycles  <= '0;
         hold_cnt    <= '0;
         idle_cnt    <= '0;
      end else begin
         // both qualifiers restart from zero unless their state keeps them counting
         hold_cnt <= '0;
         idle_cnt <= '0;
         case (state)
            ST_IDLE: begin
               if (cmd_acc && (cmd_op == CMD_START)) begin
                  state <= ST_ARM;
                  outs  <= outs_of(ST_ARM);
               end else if (cmd_acc && (cmd_op == CMD_CLEAR)) begin
                  run_cycles  <= '0;
                  err_timeout <= 1'b0;
               end
            end
            ST_ARM: begin
               // exit beats a coincident timeout
               if (element_fetched) begin
                  state <= ST_HOLD;
                  outs  <= outs_of(ST_HOLD);
               end else if (tmr_expire) begin
                  state       <= ST_ERROR;
                  outs        <= outs_of(ST_ERROR);
                  err_timeout <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (!element_fetched) begin
                  state <= ST_ARM;
                  outs  <= outs_of(ST_ARM);
               end else if (hold_cnt == HOLD_LAST) begin
                  state <= ST_RUN;
                  outs  <= outs_of(ST_RUN);
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            ST_RUN: begin
               if (run_cycles != '1) begin
                  run_cycles <= run_cycles + RUNCNT_W'(1);
               end
               if (cmd_acc && (cmd_op == CMD_STOP)) begin
                  state <= ST_DRAIN;
                  outs  <= outs_of(ST_DRAIN);
               end else if (cmd_acc && (cmd_op == CMD_CLEAR)) begin
                  state <= ST_IDLE;
                  outs  <= outs_of(ST_IDLE);
               end
            end
            ST_DRAIN: begin
               if (drain_exit) begin
                  state <= ST_IDLE;
                  outs  <= outs_of(ST_IDLE);
               end else if (tmr_expire) begin
                  state       <= ST_ERROR;
                  outs        <= outs_of(ST_ERROR);
                  err_timeout <= 1'b1;
               end else if (ctrl_idle) begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
            end
            ST_ERROR: begin
               if (cmd_acc && (cmd_op == CMD_CLEAR)) begin
                  state       <= ST_IDLE;
                  outs        <= outs_of(ST_IDLE);
                  err_timeout <= 1'b0;
                  run_cycles  <= '0;
               end
            end
            default: begin
               state <= ST_IDLE;
               outs  <= outs_of(ST_IDLE);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_consumer_lifecycle_ctrl.sv
// tb/tb_consumer_lifecycle_ctrl.sv - self-checking bench for consumer_lifecycle_ctrl

module tb_consumer_lifecycle_ctrl;

   localparam int RC = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic [1:0]  cmd_op = 2'd0;
   logic        cmd_ready;
   logic        element_fetched = 1'b0;
   logic        ctrl_idle = 1'b0;
   logic [15:0] timeout_limit = 16'd0;
   logic        manual_reset;
   logic        monitor_on;
   logic [2:0]  state_o;
   logic        err_timeout;
   logic [31:0] run_cycles;

   int n_vec = 0;
   int n_err = 0;

   // reference model: state number, cycles spent in it, consecutive idle cycles
   int          m_st = 0;
   int          m_tis = 0;
   int          m_idle = 0;
   logic        m_err = 1'b0;
   logic [31:0] m_run = 32'd0;

   logic [38:0] dut_vec;
   localparam logic [38:0] RESET_VEC = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0};

   assign dut_vec = {state_o, manual_reset, monitor_on, cmd_ready, err_timeout, run_cycles};

   always #5 clk = ~clk;

   consumer_lifecycle_ctrl #(.RESET_CYCLES(RC), .TIMEOUT_W(16), .RUNCNT_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_op          (cmd_op),
      .cmd_ready       (cmd_ready),
      .element_fetched (element_fetched),
      .ctrl_idle       (ctrl_idle),
      .timeout_limit   (timeout_limit),
      .manual_reset    (manual_reset),
      .monitor_on      (monitor_on),
      .state_o         (state_o),
      .err_timeout     (err_timeout),
      .run_cycles      (run_cycles)
   );

   function automatic logic [38:0] exp_vec();
      logic mon, mr, rdy;
      mon = (m_st == 1) || (m_st == 2) || (m_st == 3);
      mr  = (m_st == 3) || (m_st == 4);
      rdy = (m_st == 0) || (m_st == 3) || (m_st == 5);
      return {3'(m_st), mr, mon, rdy, m_err, m_run};
   endfunction

   task automatic model_reset();
      m_st = 0; m_tis = 0; m_idle = 0; m_err = 1'b0; m_run = 32'd0;
   endtask

   task automatic model_step();
      int ns;
      bit acc, to;
      ns  = m_st;
      acc = cmd_valid && ((m_st == 0) || (m_st == 3) || (m_st == 5));
      to  = (timeout_limit != 16'd0) && (m_tis + 1 >= int'(timeout_limit));
      case (m_st)
         0: if (acc && cmd_op == 2'd1) ns = 1;
            else if (acc && cmd_op == 2'd3) begin m_run = 32'd0; m_err = 1'b0; end
         1: if (element_fetched) ns = 2;
            else if (to) begin ns = 5; m_err = 1'b1; end
         2: if (!element_fetched) ns = 1;
            else if (m_tis + 1 >= RC) ns = 3;
         3: begin
            if (m_run != 32'hFFFF_FFFF) m_run = m_run + 32'd1;
            if (acc && cmd_op == 2'd2) ns = 4;
            else if (acc && cmd_op == 2'd3) ns = 0;
         end
         4: begin
            m_idle = ctrl_idle ? m_idle + 1 : 0;
            if (m_idle >= 2) ns = 0;
            else if (to) begin ns = 5; m_err = 1'b1; end
         end
         5: if (acc && cmd_op == 2'd3) begin ns = 0; m_err = 1'b0; m_run = 32'd0; end
         default: ns = 0;
      endcase
      if (ns != m_st) begin m_tis = 0; m_idle = 0; end
      else m_tis++;
      m_st = ns;
   endtask

   task automatic tick();
      if (rst_n) model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op);
      cmd_valid = 1'b1;
      cmd_op = op;
      tick();
      cmd_valid = 1'b0;
      cmd_op = 2'd0;
   endtask

   task automatic test_reset();
      model_reset();
      tick();
      tick();
      n_vec++;
      if (dut_vec !== RESET_VEC) begin
         n_err++; $display("FAIL reset_values: got %h want %h", dut_vec, RESET_VEC);
      end
      rst_n = 1'b1;
      tick();
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++; $display("FAIL idle_after_reset: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_start_hold();
      timeout_limit = 16'd0;
      issue(2'd1);
      n_vec++;
      if (monitor_on !== 1'b1 || state_o !== 3'd1 || cmd_ready !== 1'b0) begin
         n_err++; $display("FAIL start_arm: mon=%b st=%0d rdy=%b want 1/1/0", monitor_on, state_o, cmd_ready);
      end
      repeat (4) tick();
      element_fetched = 1'b1;
      tick();
      for (int i = 1; i <= RC; i++) begin
         tick();
         n_vec++;
         if (manual_reset !== (i == RC) || state_o !== ((i == RC) ? 3'd3 : 3'd2)) begin
            n_err++; $display("FAIL hold_len: cycle %0d mr=%b st=%0d", i, manual_reset, state_o);
         end
      end
      n_vec++;
      if (dut_vec !== exp_vec()) begin
         n_err++; $display("FAIL run_entry: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_run_drain();
      ctrl_idle = 1'b0;
      repeat (99) tick();
      issue(2'd2);
      n_vec++;
      if (state_o !== 3'd4 || monitor_on !== 1'b0 || manual_reset !== 1'b1 || run_cycles !== 32'd100) begin
         n_err++; $display("FAIL stop_drain: st=%0d mon=%b mr=%b run=%0d want 4/0/1/100", state_o, monitor_on, manual_reset, run_cycles);
      end
      repeat (10) tick();
      ctrl_idle = 1'b1;
      tick();
      n_vec++;
      if (state_o !== 3'd4 || manual_reset !== 1'b1) begin
         n_err++; $display("FAIL drain_first_idle: st=%0d mr=%b want 4/1", state_o, manual_reset);
      end
      tick();
      n_vec++;
      if (dut_vec !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd100} || dut_vec !== exp_vec()) begin
         n_err++; $display("FAIL drain_done: got %h want %h", dut_vec, exp_vec());
      end
      ctrl_idle = 1'b0;
   endtask

   task automatic test_timeout();
      element_fetched = 1'b0;
      timeout_limit = 16'd8;
      issue(2'd1);
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_vec++;
         if (state_o !== ((i == 8) ? 3'd5 : 3'd1)) begin
            n_err++; $display("FAIL arm_timeout: cycle %0d st=%0d", i, state_o);
         end
      end
      n_vec++;
      if (err_timeout !== 1'b1 || cmd_ready !== 1'b1 || monitor_on !== 1'b0 || manual_reset !== 1'b0) begin
         n_err++; $display("FAIL error_outputs: err=%b rdy=%b mon=%b mr=%b want 1/1/0/0", err_timeout, cmd_ready, monitor_on, manual_reset);
      end
      issue(2'd3);
      n_vec++;
      if (dut_vec !== RESET_VEC || dut_vec !== exp_vec()) begin
         n_err++; $display("FAIL error_clear: got %h want %h", dut_vec, RESET_VEC);
      end
   endtask

   task automatic test_coincide_and_abort();
      timeout_limit = 16'd8;
      issue(2'd1);
      repeat (7) tick();
      element_fetched = 1'b1;
      tick();
      n_vec++;
      if (state_o !== 3'd2 || err_timeout !== 1'b0) begin
         n_err++; $display("FAIL coincide: st=%0d err=%b want 2/0", state_o, err_timeout);
      end
      repeat (RC + 3) tick();
      issue(2'd3);
      n_vec++;
      if (state_o !== 3'd0 || monitor_on !== 1'b0 || manual_reset !== 1'b0 || dut_vec !== exp_vec()) begin
         n_err++; $display("FAIL run_abort: got %h want %h", dut_vec, exp_vec());
      end
   endtask

   task automatic test_glitch();
      timeout_limit = 16'd0;
      element_fetched = 1'b1;
      issue(2'd1);
      tick();
      repeat (6) tick();
      element_fetched = 1'b0;
      tick();
      n_vec++;
      if (state_o !== 3'd1 || manual_reset !== 1'b0) begin
         n_err++; $display("FAIL glitch_rearm: st=%0d mr=%b want 1/0", state_o, manual_reset);
      end
      element_fetched = 1'b1;
      tick();
      for (int i = 1; i <= RC; i++) begin
         tick();
         n_vec++;
         if (manual_reset !== (i == RC)) begin
            n_err++; $display("FAIL glitch_hold: cycle %0d mr=%b", i, manual_reset);
         end
      end
      issue(2'd3);
   endtask

   task automatic test_async_reset();
      timeout_limit = 16'd0;
      element_fetched = 1'b1;
      issue(2'd1);
      repeat (RC + 1) tick();
      issue(2'd2);
      repeat (3) tick();
      n_vec++;
      if (state_o !== 3'd4 || dut_vec !== exp_vec()) begin
         n_err++; $display("FAIL pre_reset_drain: got %h want %h", dut_vec, exp_vec());
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if (dut_vec !== RESET_VEC) begin
         n_err++; $display("FAIL async_reset: got %h want %h", dut_vec, RESET_VEC);
      end
      tick();
      rst_n = 1'b1;
      element_fetched = 1'b0;
   endtask

   task automatic test_random();
      int lims [4] = '{0, 3, 7, 20};
      for (int i = 0; i < 2000; i++) begin
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_op = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) element_fetched = ~element_fetched;
         ctrl_idle = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 63) == 0) timeout_limit = 16'(lims[$urandom_range(0, 3)]);
         tick();
         n_vec++;
         if (dut_vec !== exp_vec()) begin
            n_err++; $display("FAIL random cycle %0d: got %h want %h", i, dut_vec, exp_vec());
         end
      end
      cmd_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_start_hold();
      test_run_drain();
      test_timeout();
      test_coincide_and_abort();
      test_glitch();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
